// File: rtl/test_rtl_dma32_mem_responder_if.sv
// DMA32 request/data bus between an accelerator (master) and the memory-side responder (slave).
interface test_rtl_dma32_mem_responder_if;
    logic        dma_read_ctrl_valid;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic [4:0]  dma_read_ctrl_data_user;
    logic        dma_read_chnl_valid;
    logic [31:0] dma_read_chnl_data;
    logic        dma_read_chnl_ready;
    logic        dma_write_ctrl_valid;
    logic        dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index;
    logic [31:0] dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic [4:0]  dma_write_ctrl_data_user;
    logic        dma_write_chnl_valid;
    logic [31:0] dma_write_chnl_data;
    logic        dma_write_chnl_ready;

    modport master (
        output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
               dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_ctrl_data_user,
               dma_write_chnl_valid, dma_write_chnl_data,
        input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
               dma_write_ctrl_ready, dma_write_chnl_ready
    );

    modport slave (
        input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
               dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_ctrl_data_user,
               dma_write_chnl_valid, dma_write_chnl_data,
        output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
               dma_write_ctrl_ready, dma_write_chnl_ready
    );
endinterface

// File: rtl/test_rtl_dma32_mem_responder.sv
// Memory-side DMA32 responder backed by a 2^MEM_ADDR_W x 32 array; one read or write burst at a time.
// Optional bounds/size checking with a sticky err flag: define DMA32_RSP_BOUNDS_CHECK_EN.
module test_rtl_dma32_mem_responder #(
    parameter int MEM_ADDR_W = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    test_rtl_dma32_mem_responder_if.slave         bus,
    output logic                                  busy,
    output logic                                  err
);
    localparam int                    MEM_DEPTH  = 1 << MEM_ADDR_W;
    localparam logic [32:0]           DEPTH_33   = 33'd1 << MEM_ADDR_W;
    localparam logic [MEM_ADDR_W-1:0] ADDR_ONE   = {{(MEM_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [MEM_ADDR_W-1:0] ADDR_TOP   = {MEM_ADDR_W{1'b1}};
    localparam logic [31:0]           BAD_WORD   = 32'hDEADBEEF;
    localparam logic [2:0]            WORD_SIZE  = 3'b010;
`ifdef DMA32_RSP_BOUNDS_CHECK_EN
    localparam logic                  CHECK_EN   = 1'b1;
`else
    localparam logic                  CHECK_EN   = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2
    } state_t;

    state_t                  state_r, state_next_s;
    logic [31:0]             mem_r [0:MEM_DEPTH-1];
    logic [MEM_ADDR_W-1:0]   addr_r;
    logic [31:0]             count_r;
    logic                    oob_r;
    logic                    rd_valid_r;
    logic [31:0]             rd_data_r;
    logic                    busy_r;
    logic                    err_r;

    logic                    rd_accept_s, wr_accept_s, rd_beat_s, wr_beat_s, last_beat_s;
    logic [31:0]             req_index_s, req_length_s;
    logic [2:0]              req_size_s;
    logic [MEM_ADDR_W-1:0]   idx_addr_s;
    logic [32:0]             req_end_s;
    logic                    req_bad_s, first_oob_s, idx_top_s, addr_top_s;
    logic                    unused_ok_s;

    assign unused_ok_s = &{1'b0, bus.dma_read_ctrl_data_user, bus.dma_write_ctrl_data_user};

    assign bus.dma_read_ctrl_ready  = (state_r == ST_IDLE);
    assign bus.dma_write_ctrl_ready = (state_r == ST_IDLE) && !bus.dma_read_ctrl_valid;
    assign bus.dma_read_chnl_valid  = rd_valid_r;
    assign bus.dma_read_chnl_data   = rd_data_r;
    assign bus.dma_write_chnl_ready = (state_r == ST_WR_BURST);
    assign busy                     = busy_r;
    assign err                      = err_r;

    // Request fields come from whichever control channel is being accepted; read wins ties.
    assign req_index_s  = rd_accept_s ? bus.dma_read_ctrl_data_index  : bus.dma_write_ctrl_data_index;
    assign req_length_s = rd_accept_s ? bus.dma_read_ctrl_data_length : bus.dma_write_ctrl_data_length;
    assign req_size_s   = rd_accept_s ? bus.dma_read_ctrl_data_size   : bus.dma_write_ctrl_data_size;
    assign idx_addr_s   = req_index_s[MEM_ADDR_W-1:0];
    assign req_end_s    = {1'b0, req_index_s} + {1'b0, req_length_s};
    assign req_bad_s    = (req_end_s > DEPTH_33) || (req_size_s != WORD_SIZE);
    // oob_r marks that addr_r has run past the top of the array (only tracked when checking).
    assign first_oob_s  = CHECK_EN && ((req_index_s >> MEM_ADDR_W) != 32'd0);
    assign idx_top_s    = CHECK_EN && (idx_addr_s == ADDR_TOP);
    assign addr_top_s   = CHECK_EN && (addr_r == ADDR_TOP);
    assign last_beat_s  = (count_r == 32'd1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and per-cycle handshake strobes.
    always_comb begin
        state_next_s = state_r;
        rd_accept_s  = 1'b0;
        wr_accept_s  = 1'b0;
        rd_beat_s    = 1'b0;
        wr_beat_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.dma_read_ctrl_valid) begin
                    rd_accept_s  = 1'b1;
                    state_next_s = (bus.dma_read_ctrl_data_length != 32'd0) ? ST_RD_BURST : ST_IDLE;
                end else if (bus.dma_write_ctrl_valid) begin
                    wr_accept_s  = 1'b1;
                    state_next_s = (bus.dma_write_ctrl_data_length != 32'd0) ? ST_WR_BURST : ST_IDLE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_BURST: begin
                if (rd_valid_r && bus.dma_read_chnl_ready) begin
                    rd_beat_s    = 1'b1;
                    state_next_s = last_beat_s ? ST_IDLE : ST_RD_BURST;
                end else begin
                    state_next_s = ST_RD_BURST;
                end
            end
            ST_WR_BURST: begin
                if (bus.dma_write_chnl_valid) begin
                    wr_beat_s    = 1'b1;
                    state_next_s = last_beat_s ? ST_IDLE : ST_WR_BURST;
                end else begin
                    state_next_s = ST_WR_BURST;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Burst datapath: for reads addr_r points at the word to prefetch after the one on the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r     <= '0;
            count_r    <= 32'd0;
            oob_r      <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= 32'd0;
        end else if (rd_accept_s) begin
            addr_r  <= idx_addr_s + ADDR_ONE;
            count_r <= req_length_s;
            oob_r   <= first_oob_s || idx_top_s;
            if (req_length_s != 32'd0) begin
                rd_valid_r <= 1'b1;
                rd_data_r  <= first_oob_s ? BAD_WORD : mem_r[idx_addr_s];
            end
        end else if (wr_accept_s) begin
            addr_r  <= idx_addr_s;
            count_r <= req_length_s;
            oob_r   <= first_oob_s;
        end else if (rd_beat_s) begin
            count_r <= count_r - 32'd1;
            if (last_beat_s) begin
                rd_valid_r <= 1'b0;
            end else begin
                rd_data_r <= oob_r ? BAD_WORD : mem_r[addr_r];
                addr_r    <= addr_r + ADDR_ONE;
                oob_r     <= oob_r || addr_top_s;
            end
        end else if (wr_beat_s) begin
            count_r <= count_r - 32'd1;
            addr_r  <= addr_r + ADDR_ONE;
            oob_r   <= oob_r || addr_top_s;
        end
    end

    // Backing array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_beat_s && !oob_r) begin
            mem_r[addr_r] <= bus.dma_write_chnl_data;
        end
    end

    // Registered busy tracks the state the FSM is about to enter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

    // Sticky error for requests running past the array or using a non-word beat size.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (CHECK_EN && (rd_accept_s || wr_accept_s) && req_bad_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
endmodule

// File: tb/tb_test_rtl_dma32_mem_responder.sv
// Self-checking bench for test_rtl_dma32_mem_responder (16-word array) with a read-data scoreboard.
module tb_test_rtl_dma32_mem_responder;
`ifdef DMA32_RSP_BOUNDS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    logic busy;
    logic err;
    test_rtl_dma32_mem_responder_if bus();

    test_rtl_dma32_mem_responder #(.MEM_ADDR_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        int          idx;
        int          len;
        int          mode;
        logic [31:0] seed;
        logic        exp_err;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_q [$];
    logic        rc_hs, wc_hs, rd_hs, wr_hs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input int a);
        if (CHK && a >= DEPTH) return 32'hDEADBEEF;
        else return ref_mem[a % DEPTH];
    endfunction

    function automatic void ref_write(input int a, input logic [31:0] d);
        if (!(CHK && a >= DEPTH)) ref_mem[a % DEPTH] = d;
    endfunction

    // Evaluate handshakes just before the next edge, score read beats, then advance one cycle.
    task automatic tick();
        logic [31:0] e;
        #1;
        rc_hs = bus.dma_read_ctrl_valid && bus.dma_read_ctrl_ready;
        wc_hs = bus.dma_write_ctrl_valid && bus.dma_write_ctrl_ready;
        rd_hs = bus.dma_read_chnl_valid && bus.dma_read_chnl_ready;
        wr_hs = bus.dma_write_chnl_valid && bus.dma_write_chnl_ready;
        if (rd_hs) begin
            if (exp_q.size() == 0) begin
                check("extra_read_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("read_data", bus.dma_read_chnl_data, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic is_wr, input int idx, input int len, input int mode,
                           input logic [31:0] seed);
        int beats;
        int guard;
        int ph;
        logic        pre_valid;
        logic [31:0] pre_data;
        if (is_wr) begin
            bus.dma_write_ctrl_valid       = 1'b1;
            bus.dma_write_ctrl_data_index  = idx;
            bus.dma_write_ctrl_data_length = len;
            bus.dma_write_ctrl_data_size   = 3'b010;
        end else begin
            bus.dma_read_ctrl_valid       = 1'b1;
            bus.dma_read_ctrl_data_index  = idx;
            bus.dma_read_ctrl_data_length = len;
            bus.dma_read_ctrl_data_size   = 3'b010;
            for (int k = 0; k < len; k++) exp_q.push_back(ref_read(idx + k));
        end
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!(is_wr ? wc_hs : rc_hs) && guard < 20);
        check("ctrl_accept_cycles", guard, 1);
        bus.dma_read_ctrl_valid  = 1'b0;
        bus.dma_write_ctrl_valid = 1'b0;
        beats = 0;
        guard = 0;
        ph = 0;
        if (len == 0) begin
            for (int c = 0; c < 3; c++) begin
                check("len0_busy", busy, 1'b0);
                check("len0_rd_valid", bus.dma_read_chnl_valid, 1'b0);
                check("len0_wr_ready", bus.dma_write_chnl_ready, 1'b0);
                tick();
            end
        end else if (!is_wr) begin
            check("first_beat_valid", bus.dma_read_chnl_valid, 1'b1);
            while (beats < len && guard < 100) begin
                bus.dma_read_chnl_ready = (mode == 0) ? 1'b1 : ((ph % 2) == 0);
                ph++;
                pre_valid = bus.dma_read_chnl_valid;
                pre_data  = bus.dma_read_chnl_data;
                tick();
                if (rd_hs) beats++;
                else if (pre_valid && bus.dma_read_chnl_valid) check("hold_data", bus.dma_read_chnl_data, pre_data);
                guard++;
            end
            bus.dma_read_chnl_ready = 1'b0;
            check("read_beats", beats, len);
        end else begin
            while (beats < len && guard < 100) begin
                bus.dma_write_chnl_valid = 1'b1;
                bus.dma_write_chnl_data  = seed + beats;
                tick();
                if (wr_hs) begin
                    ref_write(idx + beats, seed + beats);
                    beats++;
                end
                guard++;
            end
            bus.dma_write_chnl_valid = 1'b0;
            check("write_beats", beats, len);
        end
        check("busy_after", busy, 1'b0);
        check("rd_valid_after", bus.dma_read_chnl_valid, 1'b0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        vec_t vecs [9];
        int   beats;
        int   guard;
        vecs[0] = '{1'b1, 0,  4, 0, 32'd100, 1'b0};
        vecs[1] = '{1'b1, 8,  4, 0, 32'd1,   1'b0};
        vecs[2] = '{1'b0, 8,  4, 0, 32'd0,   1'b0};
        vecs[3] = '{1'b0, 8,  3, 1, 32'd0,   1'b0};
        vecs[4] = '{1'b0, 5,  0, 0, 32'd0,   1'b0};
        vecs[5] = '{1'b1, 3,  0, 0, 32'd0,   1'b0};
        vecs[6] = '{1'b1, 14, 4, 0, 32'd200, CHK};
        vecs[7] = '{1'b0, 14, 4, 0, 32'd0,   CHK};
        vecs[8] = '{1'b0, 0,  4, 1, 32'd0,   CHK};

        rst = 1'b0;
        bus.dma_read_ctrl_valid = 1'b0;   bus.dma_read_ctrl_data_index = 32'd0;
        bus.dma_read_ctrl_data_length = 32'd0; bus.dma_read_ctrl_data_size = 3'b010;
        bus.dma_read_ctrl_data_user = 5'd0; bus.dma_read_chnl_ready = 1'b0;
        bus.dma_write_ctrl_valid = 1'b0;  bus.dma_write_ctrl_data_index = 32'd0;
        bus.dma_write_ctrl_data_length = 32'd0; bus.dma_write_ctrl_data_size = 3'b010;
        bus.dma_write_ctrl_data_user = 5'd0; bus.dma_write_chnl_valid = 1'b0;
        bus.dma_write_chnl_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rd_valid", bus.dma_read_chnl_valid, 1'b0);
        check("rst_rd_data", bus.dma_read_chnl_data, 32'd0);
        check("rst_rd_ctrl_ready", bus.dma_read_ctrl_ready, 1'b1);
        check("rst_wr_chnl_ready", bus.dma_write_chnl_ready, 1'b0);
        rst = 1'b1;

        for (int v = 0; v < 9; v++) begin
            run_txn(vecs[v].is_wr, vecs[v].idx, vecs[v].len, vecs[v].mode, vecs[v].seed);
            check($sformatf("err_after_vec%0d", v), err, vecs[v].exp_err);
        end

        // Simultaneous read and write requests: read first, write waits for the burst to end.
        exp_q.push_back(ref_read(8));
        exp_q.push_back(ref_read(9));
        bus.dma_read_ctrl_valid = 1'b1;  bus.dma_read_ctrl_data_index = 32'd8;
        bus.dma_read_ctrl_data_length = 32'd2;
        bus.dma_write_ctrl_valid = 1'b1; bus.dma_write_ctrl_data_index = 32'd4;
        bus.dma_write_ctrl_data_length = 32'd2;
        bus.dma_read_chnl_ready = 1'b1;
        tick();
        check("pri_rd_accept", rc_hs, 1'b1);
        check("pri_wr_held", wc_hs, 1'b0);
        bus.dma_read_ctrl_valid = 1'b0;
        beats = 0;
        guard = 0;
        wc_hs = 1'b0;
        while (!wc_hs && guard < 20) begin
            tick();
            if (rd_hs) beats++;
            guard++;
        end
        check("pri_wr_accept", wc_hs, 1'b1);
        check("pri_rd_beats_before_wr", beats, 2);
        bus.dma_write_ctrl_valid = 1'b0;
        bus.dma_read_chnl_ready = 1'b0;
        beats = 0;
        guard = 0;
        while (beats < 2 && guard < 20) begin
            bus.dma_write_chnl_valid = 1'b1;
            bus.dma_write_chnl_data  = 32'd300 + beats;
            tick();
            if (wr_hs) begin
                ref_write(4 + beats, 32'd300 + beats);
                beats++;
            end
            guard++;
        end
        bus.dma_write_chnl_valid = 1'b0;
        check("pri_wr_beats", beats, 2);
        run_txn(1'b0, 4, 2, 0, 32'd0);

        // Reset during the second beat of a five-beat read.
        exp_q.push_back(ref_read(8));
        bus.dma_read_ctrl_valid = 1'b1;  bus.dma_read_ctrl_data_index = 32'd8;
        bus.dma_read_ctrl_data_length = 32'd5;
        tick();
        check("rstb_accept", rc_hs, 1'b1);
        bus.dma_read_ctrl_valid = 1'b0;
        bus.dma_read_chnl_ready = 1'b1;
        tick();
        check("rstb_beat1", rd_hs, 1'b1);
        bus.dma_read_chnl_ready = 1'b0;
        tick();
        check("rstb_beat2_valid", bus.dma_read_chnl_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rstb_valid", bus.dma_read_chnl_valid, 1'b0);
        check("rstb_data", bus.dma_read_chnl_data, 32'd0);
        check("rstb_busy", busy, 1'b0);
        check("rstb_err", err, 1'b0);
        check("rstb_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Channel inputs outside a burst must be ignored.
        bus.dma_write_chnl_valid = 1'b1;
        bus.dma_write_chnl_data  = 32'h00000BAD;
        bus.dma_read_chnl_ready  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("idle_wr_hs", wr_hs, 1'b0);
            check("idle_rd_valid", bus.dma_read_chnl_valid, 1'b0);
        end
        bus.dma_write_chnl_valid = 1'b0;
        bus.dma_read_chnl_ready  = 1'b0;
        run_txn(1'b0, 8, 4, 0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/test_rtl_dma32_mem_responder.md
TEST_RTL_DMA32_MEM_RESPONDER -- requirements
Module: test_rtl_dma32_mem_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_W, default 10, meaning log2 of memory depth in 32-bit words.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have read-ctrl ports: dma_read_ctrl_valid in 1, dma_read_ctrl_ready out 1, dma_read_ctrl_data_index in 32 (word address), dma_read_ctrl_data_length in 32 (beats), dma_read_ctrl_data_size in 3, dma_read_ctrl_data_user in 5.
REQ-005 SHALL have read-data ports: dma_read_chnl_valid out 1, dma_read_chnl_data out 32, dma_read_chnl_ready in 1.
REQ-006 SHALL have write-ctrl ports mirroring REQ-004 with prefix dma_write_ctrl_.
REQ-007 SHALL have write-data ports: dma_write_chnl_valid in 1, dma_write_chnl_data in 32, dma_write_chnl_ready out 1.
REQ-008 SHALL have status ports: busy out 1 (state != IDLE); err out 1 (sticky error, REQ-025).

Function
REQ-009 SHALL serve DMA requests from an accelerator as memory-side responder, backed by 2^MEM_ADDR_W x 32 internal array.
REQ-010 SHALL implement FSM states IDLE, RD_BURST, WR_BURST.
REQ-011 SHALL drive dma_read_ctrl_ready = (state==IDLE); dma_write_ctrl_ready = (state==IDLE) & !dma_read_ctrl_valid (read priority on simultaneous requests).
REQ-012 SHALL accept a request only on valid&ready; latch index[MEM_ADDR_W-1:0] as address and length as remaining-beat counter; size and user ignored except REQ-025.
REQ-013 SHALL, on accepted request with length 0, remain in IDLE; no beats transferred.
REQ-014 SHALL, on accepted read with length>0, enter RD_BURST and assert dma_read_chnl_valid the next cycle with data = mem[index].
REQ-015 SHALL hold dma_read_chnl_valid/data stable until dma_read_chnl_ready; on each handshake increment address, decrement count, present next word the following cycle (1 beat/cycle sustained).
REQ-016 SHALL, on handshake of the last read beat, deassert dma_read_chnl_valid next cycle and return to IDLE.
REQ-017 SHALL, on accepted write with length>0, enter WR_BURST and assert dma_write_chnl_ready = (state==WR_BURST).
REQ-018 SHALL, on each write handshake, store dma_write_chnl_data at address, increment address, decrement count; after last beat return to IDLE.
REQ-019 SHALL wrap address modulo 2^MEM_ADDR_W when not otherwise checked.
REQ-020 SHALL make data written be readable by any request accepted at least one cycle after the final write beat.
REQ-021 SHALL ignore chnl valid/ready inputs outside the matching burst state.

Reset
REQ-022 SHALL, on rst low, immediately force state IDLE, dma_read_chnl_valid 0, dma_read_chnl_data 0, address/count 0, err 0.
REQ-023 SHALL abort any in-flight burst on reset; remaining beats discarded; memory contents not reset.
REQ-024 SHALL resume accepting requests the first rising edge after rst returns high.

Configuration
REQ-025 SHALL, with DMA32_RSP_BOUNDS_CHECK_EN defined, set err sticky when accepted request has index+length > 2^MEM_ADDR_W or size != 3'b010; out-of-range read beats return 32'hDEADBEEF, out-of-range write beats dropped; burst still completes all beats.
REQ-026 SHALL, without DMA32_RSP_BOUNDS_CHECK_EN, tie err to 0 and wrap per REQ-019.

Verification
REQ-027 SHALL cover: write length 4 index 8 data 1,2,3,4, then read length 4 index 8 ready=1 -> valid first beat 1 cycle after ctrl handshake, data 1,2,3,4 on consecutive cycles, busy low after.
REQ-028 SHALL cover: read length 3 with chnl_ready toggling 1,0,1,0,1 -> each word held while ready=0, exactly 3 beats, no duplicates.
REQ-029 SHALL cover: read and write ctrl valid same cycle in IDLE -> read accepted, write_ctrl_ready 0 until read burst done, then write accepted.
REQ-030 SHALL cover: length 0 request -> busy stays 0, no chnl valid/ready asserted.
REQ-031 SHALL cover: MEM_ADDR_W=4, write index 14 length 4 -> with macro err=1 and reads of 16,17 give 32'hDEADBEEF; without macro words land at 14,15,0,1.
REQ-032 SHALL cover: rst low during beat 2 of 5-beat read -> valid 0 immediately, busy 0, next request served normally.
